// File: rtl/i2c_pkg.sv
// Shared i2c command/state encodings and the bus arbiter state type.
package i2c_pkg;

  localparam int unsigned CMD_W   = 3;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;

  localparam logic [CMD_W-1:0] CMD_IDLE        = 3'd0;
  localparam logic [CMD_W-1:0] CMD_START_WRITE = 3'd1;
  localparam logic [CMD_W-1:0] CMD_START_READ  = 3'd2;
  localparam logic [CMD_W-1:0] CMD_WRITE_DATA  = 3'd3;
  localparam logic [CMD_W-1:0] CMD_READ_DATA   = 3'd4;
  localparam logic [CMD_W-1:0] CMD_STOP        = 3'd5;

  localparam logic [STATE_W-1:0] STATE_IDLE  = 2'b00;
  localparam logic [STATE_W-1:0] STATE_BUSY  = 2'b01;
  localparam logic [STATE_W-1:0] STATE_READY = 2'b10;
  localparam logic [STATE_W-1:0] STATE_ERROR = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_OWNED      = 2'd1,
    ARB_FORCE_STOP = 2'd2
  } arb_state_t;

  // One requester's command payload towards i2c_master
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] slave_addr;
    logic [DATA_W-1:0] data_in;
    logic              done_reading;
  } i2c_cmd_bus_t;

endpackage

// File: rtl/i2c_bus_arbiter_rr_picker.sv
// Round-robin picker: first set bit of req_i strictly after last_i, wrapping.
module i2c_bus_arbiter_rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan offsets from farthest to nearest so the nearest candidate wins
  always_comb begin
    int unsigned cand;
    cand    = 0;
    valid_o = |req_i;
    idx_o   = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = (32'(last_i) + k) % NUM_REQ;
      if (req_i[IDX_W'(cand)]) idx_o = IDX_W'(cand);
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one i2c_master command port among NUM_REQ drivers, granting whole
// transactions round-robin, with a stall watchdog that forces the bus free.
module i2c_bus_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_slave_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_in,
  input  logic [NUM_REQ-1:0]         req_done_reading,
  output logic [NUM_REQ*STATE_W-1:0] req_state,
  output logic [DATA_W-1:0]          req_data_out,
  output logic [CMD_W-1:0]           m_cmd,
  output logic [ADDR_W-1:0]          m_slave_addr,
  output logic [DATA_W-1:0]          m_data_in,
  output logic                       m_done_reading,
  input  logic [STATE_W-1:0]         m_state,
  input  logic [DATA_W-1:0]          m_data_out,
  output logic                       timeout_pulse,
  output logic [$clog2(NUM_REQ)-1:0] timeout_owner
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NUM_REQ-1:0] masked_q, masked_d;
  logic               pulse_q, pulse_d;
  logic [IDX_W-1:0]   to_owner_q, to_owner_d;
  logic               stop_first_q, stop_first_d;

  i2c_cmd_bus_t       req_bus [NUM_REQ];
  i2c_cmd_bus_t       owner_bus;
  logic               owner_req;
  logic [WD_W-1:0]    wd_inc;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  // Unpack per-requester slices and build the requester-facing views
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_bus[g].cmd          = req_cmd[g*CMD_W +: CMD_W];
    assign req_bus[g].slave_addr   = req_slave_addr[g*ADDR_W +: ADDR_W];
    assign req_bus[g].data_in      = req_data_in[g*DATA_W +: DATA_W];
    assign req_bus[g].done_reading = req_done_reading[g];
    assign gnt[g] = (state_q == ARB_OWNED) && (owner_q == IDX_W'(g));
    assign req_state[g*STATE_W +: STATE_W] = gnt[g] ? m_state : STATE_BUSY;
  end

  assign owner_bus     = req_bus[owner_q];
  assign owner_req     = req[owner_q];
  assign wd_inc        = wd_q + WD_W'(1);
  assign req_data_out  = m_data_out;
  assign timeout_pulse = pulse_q;
  assign timeout_owner = to_owner_q;

  i2c_bus_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (req & ~masked_q),
    .last_i  (owner_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= IDX_W'(NUM_REQ - 1);
      wd_q         <= '0;
      masked_q     <= '0;
      pulse_q      <= 1'b0;
      to_owner_q   <= '0;
      stop_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wd_q         <= wd_d;
      masked_q     <= masked_d;
      pulse_q      <= pulse_d;
      to_owner_q   <= to_owner_d;
      stop_first_q <= stop_first_d;
    end
  end

  // Next-state: owner release takes priority over the watchdog
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wd_d         = wd_q;
    masked_d     = masked_q & req;
    pulse_d      = 1'b0;
    to_owner_d   = to_owner_q;
    stop_first_d = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        wd_d = '0;
        if (pick_valid && (m_state == STATE_IDLE)) begin
          state_d = ARB_OWNED;
          owner_d = pick_idx;
        end
      end
      ARB_OWNED: begin
        if (!owner_req) begin
          wd_d         = '0;
          stop_first_d = (m_state != STATE_IDLE);
          state_d      = (m_state != STATE_IDLE) ? ARB_FORCE_STOP : ARB_IDLE;
        end else if ((owner_bus.cmd != CMD_IDLE) || (m_state == STATE_BUSY)) begin
          wd_d = '0;
        end else if (wd_inc == WD_W'(TIMEOUT_CYCLES)) begin
          wd_d              = '0;
          pulse_d           = 1'b1;
          to_owner_d        = owner_q;
          masked_d[owner_q] = 1'b1;
          stop_first_d      = (m_state != STATE_IDLE);
          state_d           = (m_state != STATE_IDLE) ? ARB_FORCE_STOP : ARB_IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end
      ARB_FORCE_STOP: begin
        wd_d = '0;
        if (!stop_first_q && (m_state == STATE_IDLE)) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Master-side mux: owner's payload, a single STOP on forced release, else idle
  always_comb begin
    m_cmd          = CMD_IDLE;
    m_slave_addr   = '0;
    m_data_in      = '0;
    m_done_reading = 1'b0;
    if (state_q == ARB_OWNED) begin
      m_cmd          = owner_bus.cmd;
      m_slave_addr   = owner_bus.slave_addr;
      m_data_in      = owner_bus.data_in;
      m_done_reading = owner_bus.done_reading;
    end else if ((state_q == ARB_FORCE_STOP) && stop_first_q) begin
      m_cmd = CMD_STOP;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: vector table plus watchdog/masking sequences.
module tb_i2c_bus_arbiter;
  import i2c_pkg::*;

  localparam logic [1:0] SI = STATE_IDLE;
  localparam logic [1:0] SB = STATE_BUSY;
  localparam logic [1:0] SR = STATE_READY;
  localparam logic [2:0] CI = CMD_IDLE;
  localparam logic [2:0] CSW = CMD_START_WRITE;
  localparam logic [2:0] CWD = CMD_WRITE_DATA;
  localparam logic [2:0] CST = CMD_STOP;
  localparam int NV = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [5:0]  req_cmd;
  logic [13:0] req_slave_addr;
  logic [15:0] req_data_in;
  logic [1:0]  req_done_reading;
  logic [3:0]  req_state;
  logic [7:0]  req_data_out;
  logic [2:0]  m_cmd;
  logic [6:0]  m_slave_addr;
  logic [7:0]  m_data_in;
  logic        m_done_reading;
  logic [1:0]  m_state;
  logic [7:0]  m_data_out;
  logic        timeout_pulse;
  logic [0:0]  timeout_owner;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .req_cmd(req_cmd),
    .req_slave_addr(req_slave_addr), .req_data_in(req_data_in),
    .req_done_reading(req_done_reading), .req_state(req_state),
    .req_data_out(req_data_out), .m_cmd(m_cmd), .m_slave_addr(m_slave_addr),
    .m_data_in(m_data_in), .m_done_reading(m_done_reading), .m_state(m_state),
    .m_data_out(m_data_out), .timeout_pulse(timeout_pulse),
    .timeout_owner(timeout_owner)
  );

  typedef struct {
    logic       r;
    logic [1:0] rq;
    logic [2:0] c0, c1;
    logic [1:0] ms;
    logic [1:0] g;
    logic [2:0] c;
    logic [3:0] rs;
  } vec_t;

  typedef struct {
    logic [1:0] g;
    logic [2:0] c;
    logic [3:0] rs;
    logic       chk_rs;
    logic       p;
    logic [7:0] dout;
  } exp_t;

  exp_t sb[$];
  vec_t tbl [NV];
  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] rq, input logic [2:0] c0, c1,
                       input logic [1:0] ms, input logic [7:0] mdo);
    @(posedge clk);
    #1;
    rst        = r;
    req        = rq;
    req_cmd    = {c1, c0};
    m_state    = ms;
    m_data_out = mdo;
  endtask

  // Pop the oldest expectation and compare the mid-cycle outputs against it
  task automatic sample();
    exp_t e;
    logic [7:0] din;
    logic [6:0] addr;
    @(negedge clk);
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e    = sb.pop_front();
    din  = (e.g == 2'b01) ? 8'h3C : (e.g == 2'b10) ? 8'hA5 : 8'h00;
    addr = (e.g == 2'b01) ? 7'h68 : (e.g == 2'b10) ? 7'h1E : 7'h00;
    cmp("gnt", 32'(gnt), 32'(e.g));
    cmp("m_cmd", 32'(m_cmd), 32'(e.c));
    cmp("timeout_pulse", 32'(timeout_pulse), 32'(e.p));
    cmp("m_data_in", 32'(m_data_in), 32'(din));
    cmp("m_slave_addr", 32'(m_slave_addr), 32'(addr));
    cmp("m_done_reading", 32'(m_done_reading), 32'(e.g == 2'b01));
    cmp("req_data_out", 32'(req_data_out), 32'(e.dout));
    if (e.chk_rs) cmp("req_state", 32'(req_state), 32'(e.rs));
  endtask

  task automatic step(input logic [1:0] rq, input logic [1:0] ms,
                      input logic [1:0] g, input logic [2:0] c, input logic p);
    drive(1'b0, rq, CI, CI, ms, 8'h77);
    sb.push_back('{g, c, 4'b0000, 1'b0, p, 8'h77});
    sample();
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 2'b00, CI,  CI,  SI, 2'b00, CI,  4'b0101};
    tbl[1]  = '{1'b0, 2'b01, CSW, CI,  SI, 2'b00, CI,  4'b0101};
    tbl[2]  = '{1'b0, 2'b01, CSW, CI,  SI, 2'b01, CSW, 4'b0100};
    tbl[3]  = '{1'b0, 2'b01, CWD, CWD, SB, 2'b01, CWD, 4'b0101};
    tbl[4]  = '{1'b0, 2'b11, CI,  CWD, SR, 2'b01, CI,  4'b0110};
    tbl[5]  = '{1'b0, 2'b10, CI,  CSW, SR, 2'b01, CI,  4'b0110};
    tbl[6]  = '{1'b0, 2'b10, CI,  CSW, SR, 2'b00, CST, 4'b0101};
    tbl[7]  = '{1'b0, 2'b10, CI,  CSW, SB, 2'b00, CI,  4'b0101};
    tbl[8]  = '{1'b0, 2'b10, CI,  CSW, SI, 2'b00, CI,  4'b0101};
    tbl[9]  = '{1'b0, 2'b10, CI,  CSW, SI, 2'b00, CI,  4'b0101};
    tbl[10] = '{1'b0, 2'b10, CI,  CSW, SI, 2'b10, CSW, 4'b0001};
    tbl[11] = '{1'b0, 2'b00, CI,  CI,  SI, 2'b10, CI,  4'b0001};
    tbl[12] = '{1'b0, 2'b11, CI,  CI,  SI, 2'b00, CI,  4'b0101};
    tbl[13] = '{1'b0, 2'b11, CSW, CI,  SI, 2'b01, CSW, 4'b0100};
    tbl[14] = '{1'b1, 2'b11, CI,  CI,  SR, 2'b01, CI,  4'b0110};
    tbl[15] = '{1'b0, 2'b11, CI,  CI,  SI, 2'b00, CI,  4'b0101};
    tbl[16] = '{1'b0, 2'b11, CI,  CI,  SI, 2'b01, CI,  4'b0100};
    tbl[17] = '{1'b0, 2'b00, CI,  CI,  SI, 2'b01, CI,  4'b0100};
    tbl[18] = '{1'b0, 2'b00, CI,  CI,  SI, 2'b00, CI,  4'b0101};

    rst              = 1'b1;
    req              = '0;
    req_cmd          = '0;
    req_slave_addr   = {7'h1E, 7'h68};
    req_data_in      = {8'hA5, 8'h3C};
    req_done_reading = 2'b01;
    m_state          = SI;
    m_data_out       = '0;
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].r, tbl[i].rq, tbl[i].c0, tbl[i].c1, tbl[i].ms, 8'(i * 37 + 5));
      sb.push_back('{tbl[i].g, tbl[i].c, tbl[i].rs, 1'b1, 1'b0, 8'(i * 37 + 5)});
      sample();
      if (i == 0) cmp("reset_timeout_owner", 32'(timeout_owner), 32'd0);
    end

    // Watchdog: requester 0 stalls with READY while requester 1 waits
    step(2'b01, SI, 2'b00, CI, 1'b0);
    for (int i = 0; i < 16; i++) step(2'b11, SR, 2'b01, CI, 1'b0);
    step(2'b11, SR, 2'b00, CST, 1'b1);
    cmp("timeout_owner", 32'(timeout_owner), 32'd0);
    step(2'b11, SI, 2'b00, CI, 1'b0);
    step(2'b11, SI, 2'b00, CI, 1'b0);
    step(2'b01, SI, 2'b10, CI, 1'b0);
    for (int i = 0; i < 4; i++) step(2'b01, SI, 2'b00, CI, 1'b0);
    step(2'b00, SI, 2'b00, CI, 1'b0);
    step(2'b01, SI, 2'b00, CI, 1'b0);

    // Release on the would-be timeout cycle: no pulse, no masking
    for (int i = 0; i < 15; i++) step(2'b01, SI, 2'b01, CI, 1'b0);
    step(2'b00, SI, 2'b01, CI, 1'b0);
    step(2'b01, SI, 2'b00, CI, 1'b0);
    step(2'b01, SI, 2'b01, CI, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
